// File: rtl/frame_tx_if.sv
// frame_tx_if: request, payload and framed-output signals of frame_tx
interface frame_tx_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [15:0]       req_len;
    logic              req_ready;
    logic              req_err;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              size_valid;
    logic [31:0]       size;
    logic              data_start;
    logic              data_valid;
    logic [DATA_W-1:0] data_out;
    logic              last;

    modport master (
        output req_valid, req_len, in_valid, in_data,
        input  req_ready, req_err, in_ready, size_valid, size, data_start, data_valid, data_out, last
    );

    modport slave (
        input  req_valid, req_len, in_valid, in_data,
        output req_ready, req_err, in_ready, size_valid, size, data_start, data_valid, data_out, last
    );
endinterface

// File: rtl/frame_tx.sv
// frame_tx: buffers a whole frame, then sends size, data_start and a bubble-free burst ending in last
// FRAME_TX_STATS_EN adds frame_cnt/err_cnt outputs
module frame_tx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int GAP    = 0
) (
    input  logic       clock,
    input  logic       rst_n,
    frame_tx_if.slave  bus
`ifdef FRAME_TX_STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, SIZE, WAIT, START, DATA} state_t;

    state_t            state, nxt;
    logic [LW-1:0]     len, cnt;
    logic [3:0]        gcnt;
    logic              err_q;
    logic              req_ok, accept, fin;
    logic [DATA_W-1:0] mem [DEPTH];

    assign req_ok = bus.req_len != 16'd0 && bus.req_len <= 16'(DEPTH);
    assign accept = bus.in_valid && state == LOAD && cnt < len;
    assign fin    = state == DATA && cnt == len - LW'(1);

    always_comb begin
        nxt            = state;
        bus.req_ready  = state == IDLE;
        bus.req_err    = err_q;
        bus.in_ready   = state == LOAD && cnt < len;
        bus.size_valid = state == SIZE;
        bus.size       = state == SIZE ? 32'(len - LW'(1)) : '0;
        bus.data_start = state == START;
        bus.data_valid = state == DATA;
        bus.data_out   = state == DATA ? mem[cnt[AW-1:0]] : '0;
        bus.last       = fin;
        case (state)
            IDLE:    nxt = bus.req_valid && req_ok ? LOAD : IDLE;
            LOAD:    nxt = accept && cnt == len - LW'(1) ? SIZE : LOAD;
            SIZE:    nxt = GAP > 0 ? WAIT : START;
            WAIT:    nxt = gcnt == 4'(GAP - 1) ? START : WAIT;
            START:   nxt = DATA;
            DATA:    nxt = fin ? IDLE : DATA;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len   <= '0;
            cnt   <= '0;
            gcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= nxt;
            err_q <= state == IDLE && bus.req_valid && !req_ok;
            if (state == IDLE && bus.req_valid && req_ok) len <= LW'(bus.req_len);
            cnt   <= accept || state == DATA ? cnt + LW'(1) : state == LOAD ? cnt : '0;
            gcnt  <= state == WAIT ? gcnt + 4'd1 : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) mem[cnt[AW-1:0]] <= bus.in_data;
    end

`ifdef FRAME_TX_STATS_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (fin) frame_cnt <= frame_cnt + 16'd1;
            if (err_q && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: drives GAP=0 and GAP=3 instances in lockstep and checks each against a frame-level model
module tb_frame_tx;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic          sv;
        logic [31:0]   sz;
        logic          ds;
        logic          dv;
        logic [DW-1:0] d;
        logic          l;
    } smp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            frames = 0;
    int            errs = 0;
    smp_t          tr [2][64];
    logic [DW-1:0] words [$];

    frame_tx_if #(.DATA_W(DW)) i0 ();
    frame_tx_if #(.DATA_W(DW)) i3 ();

    assign i3.req_valid = i0.req_valid;
    assign i3.req_len   = i0.req_len;
    assign i3.in_valid  = i0.in_valid;
    assign i3.in_data   = i0.in_data;

`ifdef FRAME_TX_STATS_EN
    logic [15:0] fc0, fc3;
    logic [7:0]  ec0, ec3;
`endif

    frame_tx #(.DATA_W(DW), .DEPTH(DEPTH), .GAP(0)) u0 (
        .clock(clk), .rst_n(rst_n), .bus(i0)
`ifdef FRAME_TX_STATS_EN
        , .frame_cnt(fc0), .err_cnt(ec0)
`endif
    );

    frame_tx #(.DATA_W(DW), .DEPTH(DEPTH), .GAP(3)) u3 (
        .clock(clk), .rst_n(rst_n), .bus(i3)
`ifdef FRAME_TX_STATS_EN
        , .frame_cnt(fc3), .err_cnt(ec3)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic load(input int len, input int mode);
        int k, ph, guard;
        logic acc;
        words.delete();
        for (int i = 0; i < len; i++) words.push_back($urandom);
        i0.req_valid = 1'b1;
        i0.req_len   = 16'(len);
        i0.in_valid  = 1'b1;
        i0.in_data   = 32'hDEAD_BEEF;
        chk("req_ready_idle", i0.req_ready, 1);
        @(negedge clk);
        i0.req_valid = 1'b0;
        i0.req_len   = 16'd0;
        k = 0; ph = 0; guard = 0;
        while (k < len && guard < 400) begin
            i0.in_valid = mode != 0 ? logic'(ph % 2 == 0) : logic'($urandom_range(0, 1));
            i0.in_data  = words[k];
            acc = i0.in_valid && i0.in_ready;
            @(negedge clk);
            if (acc) k++;
            ph++;
            guard++;
        end
        i0.in_valid = 1'b0;
        chk($sformatf("load_done_len%0d", len), k, len);
        chk("in_ready_drop", i0.in_ready, 0);
    endtask

    task automatic capture_check(input int len);
        int n, sv, nsv, nds, ndv, nl, g, idx;
        n = len + 12;
        for (int c = 0; c < n; c++) begin
            tr[0][c] = '{i0.size_valid, i0.size, i0.data_start, i0.data_valid, i0.data_out, i0.last};
            tr[1][c] = '{i3.size_valid, i3.size, i3.data_start, i3.data_valid, i3.data_out, i3.last};
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            g = d != 0 ? 3 : 0;
            sv = -1; nsv = 0; nds = 0; ndv = 0; nl = 0;
            for (int c = 0; c < n; c++) begin
                if (tr[d][c].sv) begin
                    nsv++;
                    if (sv < 0) sv = c;
                end
                if (tr[d][c].ds) nds++;
                if (tr[d][c].dv) ndv++;
                if (tr[d][c].l) nl++;
            end
            chk($sformatf("g%0d_size_pulses", g), nsv, 1);
            chk($sformatf("g%0d_start_pulses", g), nds, 1);
            chk($sformatf("g%0d_beat_count", g), ndv, len);
            chk($sformatf("g%0d_last_count", g), nl, 1);
            chk($sformatf("g%0d_size_found", g), sv >= 0 && sv <= 2, 1);
            if (sv >= 0 && sv <= 2) begin
                chk($sformatf("g%0d_size_val", g), tr[d][sv].sz, len - 1);
                chk($sformatf("g%0d_start_pos", g), tr[d][sv + 1 + g].ds, 1);
                for (int b = 0; b < len; b++) begin
                    idx = sv + 2 + g + b;
                    chk($sformatf("g%0d_beat%0d_valid", g, b), tr[d][idx].dv, 1);
                    chk($sformatf("g%0d_beat%0d_data", g, b), tr[d][idx].d, words[b]);
                    chk($sformatf("g%0d_beat%0d_last", g, b), tr[d][idx].l, b == len - 1);
                end
            end
        end
        chk("idle_after_frame0", i0.req_ready, 1);
        chk("idle_after_frame3", i3.req_ready, 1);
        frames++;
    endtask

    task automatic bad(input logic [15:0] len);
        i0.req_valid = 1'b1;
        i0.req_len   = len;
        @(negedge clk);
        i0.req_valid = 1'b0;
        i0.req_len   = 16'd0;
        chk($sformatf("req_err_%0h", len), i0.req_err, 1);
        chk($sformatf("req_err3_%0h", len), i3.req_err, 1);
        chk("err_stays_idle", i0.req_ready, 1);
        @(negedge clk);
        chk("req_err_pulse_end", i0.req_err, 0);
        chk("err_no_size", i0.size_valid, 0);
        chk("err_still_idle", i0.req_ready && i3.req_ready, 1);
        errs++;
    endtask

    initial begin
        int nb;
        i0.req_valid = 1'b0;
        i0.req_len   = 16'd0;
        i0.in_valid  = 1'b0;
        i0.in_data   = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_ready", i0.req_ready, 1);
        chk("rst_outputs", {i0.req_err, i0.in_ready, i0.size_valid, i0.data_start, i0.data_valid, i0.last}, 0);
        chk("rst_size_data", {i0.size, i0.data_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load(4, 0);     capture_check(4);
        load(1, 0);     capture_check(1);
        load(DEPTH, 1); capture_check(DEPTH);
        bad(16'd0);
        bad(16'(DEPTH + 1));
        bad(16'h8010);
        for (int r = 0; r < 3; r++) begin
            int l = $urandom_range(1, DEPTH);
            load(l, 0);
            capture_check(l);
        end

        load(5, 0);
        nb = 0;
        for (int c = 0; c < 20 && nb < 2; c++) begin
            if (i0.data_valid) nb++;
            if (nb < 2) @(negedge clk);
        end
        chk("rst_reached_beat2", nb, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {i0.size_valid, i0.data_start, i0.data_valid, i0.last, i0.in_ready}, 0);
        chk("midrst_data", i0.data_out, 0);
        chk("midrst_req_ready", i0.req_ready, 1);
        frames = 0;
        errs   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", {i0.data_valid, i0.last, i3.data_valid, i3.last}, 0);
        end

        load(2, 0);  capture_check(2);
        bad(16'd0);
        load(7, 1);  capture_check(7);
        load(3, 0);  capture_check(3);
        @(negedge clk);
`ifdef FRAME_TX_STATS_EN
        chk("frame_cnt0", fc0, frames);
        chk("frame_cnt3", fc3, frames);
        chk("err_cnt0", ec0, errs);
        chk("err_cnt3", ec3, errs);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
